line_decoder: RTL and testbench
===============================

LINE_DECODER -- requirements
Module: line_decoder

Interface
REQ-001 Parameter MIN_STABLE, default 2, range 1..15: consecutive synchronized samples required to qualify a symbol or a null.
REQ-002 Parameter MAX_HOLD, default 8, range MIN_STABLE+1..15: maximum cycles a qualified symbol may persist before an error.
REQ-003 i_clk  input  1  single clock; all state changes on the rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_ena  input  1  decoder enable, synchronous.
REQ-006 i_line_a  input  1  line wire A, asynchronous to i_clk.
REQ-007 i_line_b  input  1  line wire B, asynchronous to i_clk.
REQ-008 o_zero  output  1  one-cycle strobe, qualified ZERO symbol; feeds assembly i_zero.
REQ-009 o_one  output  1  one-cycle strobe, qualified ONE symbol; feeds assembly i_one.
REQ-010 o_head  output  1  one-cycle strobe, qualified HEAD symbol; feeds assembly i_head.
REQ-011 o_err  output  1  one-cycle strobe, protocol violation.
REQ-012 o_sym_cnt  output  5  data symbols since last HEAD, saturating.

Function
REQ-013 Symbol encoding of {a,b}: 00 NULL, 10 ONE, 01 ZERO, 11 HEAD.
REQ-014 i_line_a/i_line_b each pass through a 2-flop synchronizer; FSM sees only synchronized values.
REQ-015 States: WAIT_NULL, ARMED, QUAL, HOLD, NQUAL; 4-bit counter cnt; 2-bit register cand.
REQ-016 WAIT_NULL: count consecutive NULL samples, reset count on non-NULL; at MIN_STABLE -> ARMED.
REQ-017 ARMED: non-NULL sample S -> QUAL, cand=S, cnt=1; NULL stays.
REQ-018 QUAL: sample==cand -> cnt+1; when cnt reaches MIN_STABLE, emit strobe for cand and go HOLD with cnt=MIN_STABLE.
REQ-019 QUAL: NULL before qualification -> ARMED, no output (glitch); different non-NULL -> cand=new, cnt=1.
REQ-020 HOLD: sample==cand -> cnt+1; cnt exceeding MAX_HOLD -> o_err, WAIT_NULL.
REQ-021 HOLD: NULL -> NQUAL, cnt=1; different non-NULL -> o_err, WAIT_NULL.
REQ-022 NQUAL: NULL -> cnt+1, at MIN_STABLE -> ARMED; sample==cand -> HOLD (null glitch, no new strobe); different non-NULL -> o_err, WAIT_NULL.
REQ-023 With MIN_STABLE=1, qualification completes on the first sample (ARMED emits directly, entering HOLD).
REQ-024 Latency: strobe registered high on the (2+MIN_STABLE)-th rising edge after a stable input change, high exactly one cycle.
REQ-025 At most one of o_zero, o_one, o_head, o_err high in any cycle.
REQ-026 o_sym_cnt: cleared on o_head, +1 on o_zero or o_one, saturates at 31, unaffected by o_err.
REQ-027 i_ena=0: all strobes forced 0, FSM forced to WAIT_NULL with cnt=0, o_sym_cnt held; on re-enable the line must show MIN_STABLE NULLs before any symbol.
REQ-028 Counters never wrap: cnt saturates at 15.

Reset
REQ-029 i_rst high asynchronously clears synchronizers to 0, state to WAIT_NULL, cnt=0, cand=NULL, o_zero=o_one=o_head=o_err=0, o_sym_cnt=0.
REQ-030 Reset mid-symbol discards the symbol; no strobe is emitted for it after release.
REQ-031 Release of i_rst is synchronized externally; first state change occurs on the first edge after deassertion.

Structure
REQ-032 Package line_pkg holds symbol encoding constants, the FSM state enumeration, and default MIN_STABLE/MAX_HOLD.
REQ-033 One sub-module line_sync (2-flop synchronizer, 1 bit, async active-high reset), instantiated per wire.

Verification
REQ-034 Reset, NULL 3 cycles, ONE held 4 cycles, NULL 4 cycles (MIN_STABLE=2) -> single o_one on 4th edge after ONE applied, o_sym_cnt=1.
REQ-035 HEAD 4 cycles, then 28 alternating ZERO/ONE symbols each 4 cycles separated by 2 NULLs -> one o_head, 28 data strobes in order, o_sym_cnt=28.
REQ-036 ONE for 1 cycle between NULLs -> no strobe, no o_err; ONE 10 cycles (MAX_HOLD=8) -> o_one then o_err, next symbol ignored until 2 NULLs.
REQ-037 ONE held, switched directly to ZERO without NULL -> o_one then o_err, no o_zero.
REQ-038 33 ONE symbols after HEAD -> o_sym_cnt saturates at 31; next HEAD clears to 0.
REQ-039 i_rst pulsed while ZERO in QUAL; and i_ena dropped in HOLD -> no strobe, all outputs 0, recovery only after 2 NULLs.

Source files
------------

// File: rtl/line_pkg.sv
// Shared definitions for the two-wire line decoder: symbol codes, FSM states,
// default timing parameters and small saturating-counter helpers.
package line_pkg;

  localparam int unsigned DEF_MIN_STABLE = 2;
  localparam int unsigned DEF_MAX_HOLD   = 8;
  localparam int          SYM_CNT_W      = 5;

  // Symbol codes as {a,b}
  localparam logic [1:0] SYM_NULL = 2'b00;
  localparam logic [1:0] SYM_ZERO = 2'b01;
  localparam logic [1:0] SYM_ONE  = 2'b10;
  localparam logic [1:0] SYM_HEAD = 2'b11;

  typedef enum logic [2:0] {
    ST_WAIT_NULL = 3'd0,
    ST_ARMED     = 3'd1,
    ST_QUAL      = 3'd2,
    ST_HOLD      = 3'd3,
    ST_NQUAL     = 3'd4
  } line_state_e;

  function automatic logic [3:0] cnt_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  // Data-symbol counter update on a qualified strobe of symbol s
  function automatic logic [SYM_CNT_W-1:0] sym_cnt_next(input logic [SYM_CNT_W-1:0] c,
                                                        input logic [1:0] s);
    if (s == SYM_HEAD) return '0;
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/line_decoder_if.sv
// Bundle of the line wires, enable and decoded strobes seen around line_decoder.
interface line_decoder_if;
  import line_pkg::*;

  logic                 ena;
  logic                 line_a;
  logic                 line_b;
  logic                 zero;
  logic                 one;
  logic                 head;
  logic                 err;
  logic [SYM_CNT_W-1:0] sym_cnt;

  // Handshake: none; strobes are single-cycle pulses with no back-pressure.
  modport master (output ena, line_a, line_b, input zero, one, head, err, sym_cnt);
  modport slave  (input ena, line_a, line_b, output zero, one, head, err, sym_cnt);
endinterface

// File: rtl/line_sync.sv
// Two-flop synchronizer for one asynchronous line wire.
module line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;
endmodule

// File: rtl/line_decoder.sv
// Two-wire line decoder: qualifies NULL-separated ZERO/ONE/HEAD symbols into
// one-cycle strobes, flags protocol violations and counts data symbols.
module line_decoder
  import line_pkg::*;
#(
  parameter int unsigned MIN_STABLE = DEF_MIN_STABLE,
  parameter int unsigned MAX_HOLD   = DEF_MAX_HOLD
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ena,
  input  logic                 i_line_a,
  input  logic                 i_line_b,
  output logic                 o_zero,
  output logic                 o_one,
  output logic                 o_head,
  output logic                 o_err,
  output logic [SYM_CNT_W-1:0] o_sym_cnt,
  output line_state_e          o_dbg_state
);

  localparam logic [3:0] MS = 4'(MIN_STABLE);
  localparam logic [3:0] MH = 4'(MAX_HOLD);

  logic a_sync, b_sync;
  logic [1:0] sym;

  line_sync u_sync_a (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_line_a), .o_q(a_sync));
  line_sync u_sync_b (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_line_b), .o_q(b_sync));

  assign sym = {a_sync, b_sync};

  line_state_e          state_q;
  logic [3:0]           cnt_q;
  logic [1:0]           cand_q;
  logic                 zero_q, one_q, head_q, err_q;
  logic [SYM_CNT_W-1:0] sym_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_WAIT_NULL;
      cnt_q     <= '0;
      cand_q    <= SYM_NULL;
      zero_q    <= 1'b0;
      one_q     <= 1'b0;
      head_q    <= 1'b0;
      err_q     <= 1'b0;
      sym_cnt_q <= '0;
    end else begin
      zero_q <= 1'b0;
      one_q  <= 1'b0;
      head_q <= 1'b0;
      err_q  <= 1'b0;
      if (!i_ena) begin
        state_q <= ST_WAIT_NULL;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_WAIT_NULL: begin
            if (sym != SYM_NULL) begin
              cnt_q <= '0;
            end else if (cnt_inc(cnt_q) >= MS) begin
              state_q <= ST_ARMED;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc(cnt_q);
            end
          end
          ST_ARMED: begin
            if (sym != SYM_NULL) begin
              cand_q <= sym;
              // A single stable sample already qualifies when MIN_STABLE is 1
              if (MS == 4'd1) begin
                zero_q    <= (sym == SYM_ZERO);
                one_q     <= (sym == SYM_ONE);
                head_q    <= (sym == SYM_HEAD);
                sym_cnt_q <= sym_cnt_next(sym_cnt_q, sym);
                state_q   <= ST_HOLD;
                cnt_q     <= MS;
              end else begin
                state_q <= ST_QUAL;
                cnt_q   <= 4'd1;
              end
            end
          end
          ST_QUAL: begin
            if (sym == SYM_NULL) begin
              state_q <= ST_ARMED;
              cnt_q   <= '0;
            end else if (sym == cand_q) begin
              if (cnt_inc(cnt_q) >= MS) begin
                zero_q    <= (cand_q == SYM_ZERO);
                one_q     <= (cand_q == SYM_ONE);
                head_q    <= (cand_q == SYM_HEAD);
                sym_cnt_q <= sym_cnt_next(sym_cnt_q, cand_q);
                state_q   <= ST_HOLD;
                cnt_q     <= MS;
              end else begin
                cnt_q <= cnt_inc(cnt_q);
              end
            end else begin
              cand_q <= sym;
              cnt_q  <= 4'd1;
            end
          end
          ST_HOLD: begin
            if (sym == SYM_NULL) begin
              state_q <= (MS == 4'd1) ? ST_ARMED : ST_NQUAL;
              cnt_q   <= (MS == 4'd1) ? 4'd0 : 4'd1;
            end else if (sym == cand_q && cnt_inc(cnt_q) <= MH) begin
              cnt_q <= cnt_inc(cnt_q);
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_WAIT_NULL;
              cnt_q   <= '0;
            end
          end
          ST_NQUAL: begin
            if (sym == SYM_NULL) begin
              if (cnt_inc(cnt_q) >= MS) begin
                state_q <= ST_ARMED;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_inc(cnt_q);
              end
            end else if (sym == cand_q) begin
              // Short NULL glitch inside a held symbol: resume holding, hold budget restarts
              state_q <= ST_HOLD;
              cnt_q   <= MS;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_WAIT_NULL;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= ST_WAIT_NULL;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign o_zero      = zero_q;
  assign o_one       = one_q;
  assign o_head      = head_q;
  assign o_err       = err_q;
  assign o_sym_cnt   = sym_cnt_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_line_decoder.sv
// Bench for line_decoder: directed per-cycle table, scenario sequences with a
// symbol-order scoreboard, and random line traffic against a reference model.
module tb_line_decoder;
  import line_pkg::*;

  localparam int MS = 2;
  localparam int MH = 8;

  logic        clk;
  logic        rst;
  line_state_e dbg_state;

  line_decoder_if bus ();

  line_decoder #(.MIN_STABLE(MS), .MAX_HOLD(MH)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ena      (bus.ena),
    .i_line_a   (bus.line_a),
    .i_line_b   (bus.line_b),
    .o_zero     (bus.zero),
    .o_one      (bus.one),
    .o_head     (bus.head),
    .o_err      (bus.err),
    .o_sym_cnt  (bus.sym_cnt),
    .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_zero = 0, n_one = 0, n_head = 0, n_err = 0;
  bit sb_on = 1'b0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samples reach the decoder two edges late; a symbol is
  // accepted after MS equal samples, must be released by MS NULLs, and may
  // persist at most MH samples; anything else is a violation.
  localparam int PH_DISARMED = 0, PH_IDLE = 1, PH_CAND = 2, PH_LOCKED = 3;
  int ph, null_run, run, hold, gap, m_sym;
  logic [1:0] m_cand;
  logic [1:0] hist[$];
  logic m_zero, m_one, m_head, m_err;

  task automatic model_reset();
    hist.delete();
    hist.push_back(SYM_NULL);
    hist.push_back(SYM_NULL);
    ph = PH_DISARMED; null_run = 0; run = 0; hold = 0; gap = 0;
    m_cand = SYM_NULL; m_sym = 0;
    m_zero = 0; m_one = 0; m_head = 0; m_err = 0;
  endtask

  task automatic model_lock();
    m_zero = (m_cand == SYM_ZERO);
    m_one  = (m_cand == SYM_ONE);
    m_head = (m_cand == SYM_HEAD);
    if (m_cand == SYM_HEAD) m_sym = 0;
    else if (m_sym < 31) m_sym++;
    ph = PH_LOCKED; hold = MS; gap = 0;
  endtask

  task automatic model_fault();
    m_err = 1; ph = PH_DISARMED; null_run = 0;
  endtask

  task automatic model_edge(input logic [1:0] in_sym, input logic ena);
    logic [1:0] s;
    s = hist.pop_front();
    hist.push_back(in_sym);
    m_zero = 0; m_one = 0; m_head = 0; m_err = 0;
    if (!ena) begin
      ph = PH_DISARMED; null_run = 0;
    end else begin
      case (ph)
        PH_DISARMED: if (s == SYM_NULL) begin
                       null_run++;
                       if (null_run >= MS) ph = PH_IDLE;
                     end else null_run = 0;
        PH_IDLE: if (s != SYM_NULL) begin
                   m_cand = s; run = 1;
                   if (run >= MS) model_lock(); else ph = PH_CAND;
                 end
        PH_CAND: if (s == SYM_NULL) ph = PH_IDLE;
                 else if (s == m_cand) begin
                   run++;
                   if (run >= MS) model_lock();
                 end else begin m_cand = s; run = 1; end
        default: if (s == SYM_NULL) begin
                   gap++;
                   if (gap >= MS) ph = PH_IDLE;
                 end else if (s != m_cand) model_fault();
                 else if (gap > 0) begin gap = 0; hold = MS; end
                 else begin
                   hold++;
                   if (hold > MH) model_fault();
                 end
      endcase
    end
  endtask

  task automatic step(input logic [1:0] sym, input logic ena);
    logic [1:0] got;
    bus.line_a = sym[1];
    bus.line_b = sym[0];
    bus.ena    = ena;
    @(posedge clk);
    #1;
    model_edge(sym, ena);
    check("zero", bus.zero, m_zero);
    check("one", bus.one, m_one);
    check("head", bus.head, m_head);
    check("err", bus.err, m_err);
    check("sym_cnt", bus.sym_cnt, m_sym);
    check("exclusive", int'(bus.zero) + int'(bus.one) + int'(bus.head) + int'(bus.err) <= 1, 1);
    n_zero += bus.zero; n_one += bus.one; n_head += bus.head; n_err += bus.err;
    if (sb_on && (bus.zero || bus.one || bus.head)) begin
      got = bus.head ? SYM_HEAD : (bus.one ? SYM_ONE : SYM_ZERO);
      if (exp_q.size() == 0) check("sb_extra", int'(got), -1);
      else check("sb_order", int'(got), int'(exp_q.pop_front()));
    end
  endtask

  task automatic hold_sym(input logic [1:0] sym, input int n);
    for (int i = 0; i < n; i++) step(sym, 1'b1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    #2;
    check("rst_outs", int'({bus.zero, bus.one, bus.head, bus.err}), 0);
    check("rst_sym_cnt", bus.sym_cnt, 0);
    check("rst_state", int'(dbg_state), int'(ST_WAIT_NULL));
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] sym;
    logic       exp_zero, exp_one, exp_head, exp_err;
    logic [4:0] exp_cnt;
  } vec_t;
  vec_t tbl[11];

  int b_zero, b_one, b_head, b_err, snap;

  initial begin
    // Reset, NULL x3, ONE x4, NULL x4: o_one on the 4th edge of ONE
    tbl[0]  = '{SYM_NULL, 0, 0, 0, 0, 5'd0};
    tbl[1]  = '{SYM_NULL, 0, 0, 0, 0, 5'd0};
    tbl[2]  = '{SYM_NULL, 0, 0, 0, 0, 5'd0};
    tbl[3]  = '{SYM_ONE,  0, 0, 0, 0, 5'd0};
    tbl[4]  = '{SYM_ONE,  0, 0, 0, 0, 5'd0};
    tbl[5]  = '{SYM_ONE,  0, 0, 0, 0, 5'd0};
    tbl[6]  = '{SYM_ONE,  0, 1, 0, 0, 5'd1};
    tbl[7]  = '{SYM_NULL, 0, 0, 0, 0, 5'd1};
    tbl[8]  = '{SYM_NULL, 0, 0, 0, 0, 5'd1};
    tbl[9]  = '{SYM_NULL, 0, 0, 0, 0, 5'd1};
    tbl[10] = '{SYM_NULL, 0, 0, 0, 0, 5'd1};

    rst = 1'b1;
    bus.ena = 1'b1; bus.line_a = 1'b0; bus.line_b = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_outs", int'({bus.zero, bus.one, bus.head, bus.err}), 0);
    check("init_sym_cnt", bus.sym_cnt, 0);
    check("init_state", int'(dbg_state), int'(ST_WAIT_NULL));
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].sym, 1'b1);
      check($sformatf("tbl%0d_zero", i), bus.zero, tbl[i].exp_zero);
      check($sformatf("tbl%0d_one", i), bus.one, tbl[i].exp_one);
      check($sformatf("tbl%0d_head", i), bus.head, tbl[i].exp_head);
      check($sformatf("tbl%0d_err", i), bus.err, tbl[i].exp_err);
      check($sformatf("tbl%0d_cnt", i), bus.sym_cnt, tbl[i].exp_cnt);
    end
    check("tbl_end_state", int'(dbg_state), int'(ST_ARMED));

    // HEAD then 28 alternating data symbols, checked in order
    b_zero = n_zero; b_one = n_one; b_head = n_head; b_err = n_err;
    sb_on = 1'b1;
    exp_q.push_back(SYM_HEAD);
    hold_sym(SYM_HEAD, 4);
    for (int i = 0; i < 28; i++) begin
      hold_sym(SYM_NULL, 2);
      exp_q.push_back((i % 2) ? SYM_ONE : SYM_ZERO);
      hold_sym((i % 2) ? SYM_ONE : SYM_ZERO, 4);
    end
    hold_sym(SYM_NULL, 3);
    sb_on = 1'b0;
    check("seq_leftover", exp_q.size(), 0);
    check("seq_heads", n_head - b_head, 1);
    check("seq_zeros", n_zero - b_zero, 14);
    check("seq_ones", n_one - b_one, 14);
    check("seq_errs", n_err - b_err, 0);
    check("seq_sym_cnt", bus.sym_cnt, 28);

    // Saturation at 31, cleared by the next HEAD
    hold_sym(SYM_HEAD, 4);
    hold_sym(SYM_NULL, 2);
    for (int i = 0; i < 33; i++) begin
      hold_sym(SYM_ONE, 4);
      hold_sym(SYM_NULL, 2);
    end
    hold_sym(SYM_NULL, 2);
    check("sat_sym_cnt", bus.sym_cnt, 31);
    hold_sym(SYM_HEAD, 4);
    hold_sym(SYM_NULL, 3);
    check("head_clears", bus.sym_cnt, 0);

    // One-cycle glitch, then an over-long ONE and a symbol that must be ignored
    b_zero = n_zero; b_one = n_one; b_err = n_err;
    hold_sym(SYM_NULL, 3);
    hold_sym(SYM_ONE, 1);
    hold_sym(SYM_NULL, 4);
    check("glitch_ones", n_one - b_one, 0);
    check("glitch_errs", n_err - b_err, 0);
    hold_sym(SYM_ONE, 10);
    hold_sym(SYM_ZERO, 4);
    hold_sym(SYM_NULL, 3);
    check("long_ones", n_one - b_one, 1);
    check("long_errs", n_err - b_err, 1);
    check("ignored_zero", n_zero - b_zero, 0);
    hold_sym(SYM_ZERO, 4);
    hold_sym(SYM_NULL, 3);
    check("recover_zero", n_zero - b_zero, 1);

    // ONE switched straight to ZERO
    b_zero = n_zero; b_one = n_one; b_err = n_err;
    hold_sym(SYM_ONE, 4);
    hold_sym(SYM_ZERO, 4);
    hold_sym(SYM_NULL, 4);
    check("switch_ones", n_one - b_one, 1);
    check("switch_errs", n_err - b_err, 1);
    check("switch_zeros", n_zero - b_zero, 0);

    // Reset while ZERO is being qualified
    b_zero = n_zero;
    hold_sym(SYM_ZERO, 3);
    check("mid_qual_state", int'(dbg_state), int'(ST_QUAL));
    bus.line_a = 1'b0; bus.line_b = 1'b0;
    pulse_reset();
    hold_sym(SYM_NULL, 4);
    check("rst_no_zero", n_zero - b_zero, 0);
    hold_sym(SYM_ZERO, 4);
    hold_sym(SYM_NULL, 3);
    check("rst_recover", n_zero - b_zero, 1);

    // Enable dropped while a ONE is held
    b_one = n_one;
    hold_sym(SYM_ONE, 4);
    check("in_hold_state", int'(dbg_state), int'(ST_HOLD));
    check("in_hold_one", n_one - b_one, 1);
    snap = bus.sym_cnt;
    step(SYM_ONE, 1'b0);
    step(SYM_ONE, 1'b0);
    check("dis_state", int'(dbg_state), int'(ST_WAIT_NULL));
    check("dis_sym_held", bus.sym_cnt, snap);
    hold_sym(SYM_ONE, 3);
    hold_sym(SYM_NULL, 4);
    check("dis_no_one", n_one - b_one, 1);
    hold_sym(SYM_ONE, 4);
    hold_sym(SYM_NULL, 3);
    check("dis_recover", n_one - b_one, 2);

    // Random line traffic
    for (int seg = 0; seg < 300; seg++) begin
      logic [1:0] rs;
      logic       ren;
      int         dur;
      rs  = ($urandom_range(0, 9) < 4) ? SYM_NULL : 2'($urandom_range(1, 3));
      ren = ($urandom_range(0, 19) != 0);
      dur = $urandom_range(1, 10);
      if ($urandom_range(0, 49) == 0) pulse_reset();
      for (int k = 0; k < dur; k++) step(rs, ren);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
